// File: rtl/systolic_setup_pkg.sv
// Shared array constants and lane gating helper for the systolic input skew stage.
// Both the controller and the skew stage take their default dimensions from here.
package systolic_setup_pkg;

   localparam int SYS_N      = 8;
   localparam int DATA_WIDTH = 8;
   localparam int BUF_LAT    = 1;

   // A lane carries a real operand only for an issued, non-padding, enabled slot.
   function automatic logic lane_keep(input logic en, input logic bub, input logic msk);
      return en & ~bub & msk;
   endfunction

endpackage

// File: rtl/systolic_setup_delay_line.sv
// Fixed-depth shift register with async active-low reset and an OR-reduction of one
// tap bit across all stages (used to tell whether any flagged item is still in flight).
module delay_line #(
   parameter int DEPTH   = 1,
   parameter int WIDTH   = 1,
   parameter int TAP_BIT = 0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             tap_any_o
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_q;

   // Shift chain: stage 0 samples the input, later stages follow the previous one.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_q <= {(DEPTH*WIDTH){1'b0}};
      end else begin
         stage_q[0] <= d_i;
         for (int k = 1; k < DEPTH; k++) begin
            stage_q[k] <= stage_q[k-1];
         end
      end
   end

   // Any stage with the tap bit set.
   always_comb begin
      tap_any_o = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         tap_any_o = tap_any_o | stage_q[k][TAP_BIT];
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_setup.sv
// Input skew stage: aligns controller flags with buffer read data, zero-gates unused
// slots and delays lane i by i extra cycles to form the systolic wavefront.
module systolic_setup
   import systolic_setup_pkg::*;
#(
   parameter int N          = systolic_setup_pkg::SYS_N,
   parameter int DATA_WIDTH = systolic_setup_pkg::DATA_WIDTH,
   parameter int BUF_LAT    = systolic_setup_pkg::BUF_LAT
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    ensys_i,
   input  logic                    bubble_i,
   input  logic [N-1:0]            data_en_i,
   input  logic [N*DATA_WIDTH-1:0] data_i,
   output logic [N*DATA_WIDTH-1:0] data_o,
   output logic [N-1:0]            lane_valid_o,
   output logic                    busy_o
);

   localparam int AW = N + 2;

   logic [AW-1:0] align_d;
   logic [AW-1:0] align_q;
   logic          align_busy;
   logic          en_a;
   logic          bub_a;
   logic [N-1:0]  msk_a;
   logic [N-1:0]  keep;
   logic [N-1:0]  lane_busy;

   assign align_d = {data_en_i, bubble_i, ensys_i};

   // Flags travel alongside the buffer read so they line up with data_i.
   delay_line #(
      .DEPTH   (BUF_LAT),
      .WIDTH   (AW),
      .TAP_BIT (0)
   ) u_align (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .d_i       (align_d),
      .q_o       (align_q),
      .tap_any_o (align_busy)
   );

   assign en_a  = align_q[0];
   assign bub_a = align_q[1];
   assign msk_a = align_q[2 +: N];

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DATA_WIDTH:0] lane_d;
      logic [DATA_WIDTH:0] lane_q;

      assign keep[i] = lane_keep(en_a, bub_a, msk_a[i]);
      // Held BRAM output is ignored unless the slot is real.
      assign lane_d  = {keep[i], keep[i] ? data_i[i*DATA_WIDTH +: DATA_WIDTH]
                                         : {DATA_WIDTH{1'b0}}};

      delay_line #(
         .DEPTH   (i + 1),
         .WIDTH   (DATA_WIDTH + 1),
         .TAP_BIT (DATA_WIDTH)
      ) u_skew (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .d_i       (lane_d),
         .q_o       (lane_q),
         .tap_any_o (lane_busy[i])
      );

      assign data_o[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[DATA_WIDTH-1:0];
      assign lane_valid_o[i]                    = lane_q[DATA_WIDTH];
   end

   assign busy_o = align_busy | (|lane_busy);

endmodule

// File: tb/tb_systolic_setup.sv
// Directed bench for systolic_setup with an issue-history reference model checked
// every cycle, plus hand-computed spot values for each scenario.
module tb_systolic_setup;

   localparam int N    = 8;
   localparam int W    = 8;
   localparam int BL   = 1;
   localparam int MAXC = 2000;

   logic           clk_i = 1'b0;
   logic           rst_ni;
   logic           ensys_i;
   logic           bubble_i;
   logic [N-1:0]   data_en_i;
   logic [N*W-1:0] data_i;
   logic [N*W-1:0] data_o;
   logic [N-1:0]   lane_valid_o;
   logic           busy_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   bit             ens_h [MAXC];
   bit             bub_h [MAXC];
   logic [N-1:0]   msk_h [MAXC];
   logic [N*W-1:0] dat_h [MAXC];

   logic [N*W-1:0] batch_w [8];
   logic [N-1:0]   batch_m [8];

   systolic_setup #(.N(N), .DATA_WIDTH(W), .BUF_LAT(BL)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .ensys_i      (ensys_i),
      .bubble_i     (bubble_i),
      .data_en_i    (data_en_i),
      .data_i       (data_i),
      .data_o       (data_o),
      .lane_valid_o (lane_valid_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
      end
   endtask

   // Reference model: an element issued at cycle s reaches lane i at s+BL+1+i.
   always @(negedge clk_i) begin : model
      logic [N*W-1:0] exp_d;
      logic [N-1:0]   exp_v;
      logic           exp_b;
      int             s;
      ens_h[cyc] = ensys_i && rst_ni;
      bub_h[cyc] = bubble_i;
      msk_h[cyc] = data_en_i;
      dat_h[cyc] = data_i;
      if (!rst_ni) begin
         for (int k = 0; k <= cyc; k++) ens_h[k] = 1'b0;
      end
      exp_d = {(N*W){1'b0}};
      exp_v = {N{1'b0}};
      exp_b = 1'b0;
      for (int i = 0; i < N; i++) begin
         s = cyc - BL - 1 - i;
         if (s >= 0 && ens_h[s] && !bub_h[s] && msk_h[s][i]) begin
            exp_v[i]         = 1'b1;
            exp_d[i*W +: W]  = dat_h[s+BL][i*W +: W];
         end
      end
      for (int s2 = cyc - BL; s2 < cyc; s2++) begin
         if (s2 >= 0 && ens_h[s2]) exp_b = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
         for (int s2 = cyc - BL - 1 - i; s2 <= cyc - BL - 1; s2++) begin
            if (s2 >= 0 && ens_h[s2] && !bub_h[s2] && msk_h[s2][i]) exp_b = 1'b1;
         end
      end
      chk("model_data", data_o, exp_d);
      chk("model_valid", {56'd0, lane_valid_o}, {56'd0, exp_v});
      chk("model_busy", {63'd0, busy_o}, {63'd0, exp_b});
   end

   task automatic drive(input logic e, input logic b, input logic [N-1:0] m,
                        input logic [N*W-1:0] d);
      @(posedge clk_i);
      #1;
      ensys_i   = e;
      bubble_i  = b;
      data_en_i = m;
      data_i    = d;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, data_en_i, data_i);
   endtask

   // Issues len slots; the buffer returns slot j's word one cycle after its issue.
   task automatic run_batch(input int len, input int kreal, output int t0);
      t0 = 0;
      for (int j = 0; j <= len; j++) begin
         drive(j < len, (j < len) && (j >= kreal), batch_m[(j < len) ? j : 0],
               (j > 0) ? batch_w[j-1] : data_i);
         if (j == 0) t0 = cyc;
      end
   endtask

   task automatic at_cyc(input int c);
      while (cyc < c) @(negedge clk_i);
   endtask

   initial begin
      int t;
      logic [N*W-1:0] w;
      rst_ni    = 1'b0;
      ensys_i   = 1'b0;
      bubble_i  = 1'b0;
      data_en_i = 8'hFF;
      data_i    = 64'd0;
      idle(3);
      chk("reset_data", data_o, 64'd0);
      chk("reset_busy", {63'd0, busy_o}, 64'd0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      idle(2);

      // Single element, lane i = 0x11*(i+1)
      for (int i = 0; i < N; i++) w[i*W +: W] = 8'(8'h11 * (i + 1));
      batch_w[0] = w;
      for (int j = 0; j < 8; j++) batch_m[j] = 8'hFF;
      run_batch(1, 8, t);
      at_cyc(t + 2);
      chk("single_lane0", {56'd0, data_o[7:0]}, 64'h11);
      chk("single_valid0", {56'd0, lane_valid_o}, 64'h01);
      at_cyc(t + 9);
      chk("single_lane7", data_o, 64'h8800_0000_0000_0000);
      chk("single_valid7", {56'd0, lane_valid_o}, 64'h80);
      idle(4);

      // Streaming 1..8
      for (int j = 0; j < 8; j++) batch_w[j] = {8{8'(j + 1)}};
      run_batch(8, 8, t);
      at_cyc(t + 9);
      chk("stream_lane3", {56'd0, data_o[31:24]}, 64'd5);
      chk("stream_lane0", {56'd0, data_o[7:0]}, 64'd8);
      at_cyc(t + 16);
      chk("stream_busy_last", {63'd0, busy_o}, 64'd1);
      chk("stream_lane7_last", {56'd0, data_o[63:56]}, 64'd8);
      at_cyc(t + 17);
      chk("stream_busy_fall", {63'd0, busy_o}, 64'd0);
      idle(2);

      // Bubbles: k=3 real slots then 5 padding slots
      for (int j = 0; j < 8; j++) batch_w[j] = {8{8'hFF}};
      run_batch(8, 3, t);
      at_cyc(t + 9);
      chk("bubble_lane5_real", {56'd0, data_o[47:40]}, 64'hFF);
      at_cyc(t + 10);
      chk("bubble_lane5_pad", {56'd0, data_o[47:40]}, 64'h00);
      chk("bubble_lane5_vld", {63'd0, lane_valid_o[5]}, 64'd0);
      at_cyc(t + 11);
      chk("bubble_lane7_real", {56'd0, data_o[63:56]}, 64'hFF);
      idle(6);

      // Mask 0000_0111 with 0xAA
      for (int j = 0; j < 8; j++) begin
         batch_w[j] = {8{8'hAA}};
         batch_m[j] = 8'h07;
      end
      run_batch(4, 8, t);
      at_cyc(t + 4);
      chk("mask_lane2", {56'd0, data_o[23:16]}, 64'hAA);
      at_cyc(t + 5);
      chk("mask_data", data_o, 64'h0000_0000_00AA_AAAA);
      chk("mask_valid", {56'd0, lane_valid_o}, 64'h07);
      idle(10);

      // Per-slot mask changes across back-to-back slots
      batch_m[0] = 8'hFF; batch_m[1] = 8'h0F; batch_m[2] = 8'hF0; batch_m[3] = 8'h81;
      batch_m[4] = 8'h00; batch_m[5] = 8'h3C; batch_m[6] = 8'hFF; batch_m[7] = 8'h01;
      for (int j = 0; j < 8; j++) begin
         for (int i = 0; i < N; i++) w[i*W +: W] = 8'((j << 4) + i + 1);
         batch_w[j] = w;
      end
      run_batch(8, 8, t);
      idle(12);

      // Idle garbage on the read bus
      drive(1'b0, 1'b0, 8'hFF, {8{8'h5A}});
      idle(19);
      chk("garbage_data", data_o, 64'd0);
      chk("garbage_busy", {63'd0, busy_o}, 64'd0);

      // Reset three cycles into a stream
      for (int j = 0; j < 8; j++) batch_w[j] = {8{8'(8'h30 + j)}};
      for (int j = 0; j < 3; j++) drive(1'b1, 1'b0, 8'hFF, (j > 0) ? batch_w[j-1] : data_i);
      @(posedge clk_i);
      #1;
      chk("pre_reset_busy", {63'd0, busy_o}, 64'd1);
      rst_ni  = 1'b0;
      ensys_i = 1'b0;
      data_i  = batch_w[2];
      #1;
      chk("midrst_data", data_o, 64'd0);
      chk("midrst_valid", {56'd0, lane_valid_o}, 64'd0);
      chk("midrst_busy", {63'd0, busy_o}, 64'd0);
      idle(2);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      idle(10);
      chk("post_reset_busy", {63'd0, busy_o}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
